// File: rtl/spi_frame_rx.sv
// spi_frame_rx: serial frame receiver in front of the Mandelbrot pixel core.
// It brings the SPI master's spi_clk/spi_en/spi_data into the clk domain and
// assembles each complete frame into one complex coordinate (c_re, c_im).
// The frame is then offered on a valid/ready handshake with a single holding
// register, and a frame lost to back-pressure is flagged on overrun.
// Optional feature macro: SPI_RX_PARITY_EN. When it is defined, each frame
// carries one trailing even-parity bit, and a bad frame pulses parity_err.
module spi_frame_rx #(
    parameter int FRAME_W = 64
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   spi_clk,
    input  logic                   spi_en,
    input  logic                   spi_data,
    input  logic                   frame_ready,
    output logic                   frame_valid,
    output logic [FRAME_W/2-1:0]   c_re,
    output logic [FRAME_W/2-1:0]   c_im,
    output logic                   busy,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int HALF_W = FRAME_W / 2;
`ifdef SPI_RX_PARITY_EN
    localparam int LEN = FRAME_W + 1;
`else
    localparam int LEN = FRAME_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

`ifdef SPI_RX_PARITY_EN
    // A frame is good when the XOR of all its bits, including parity, is zero.
    function automatic logic even_parity_ok(input logic [LEN-1:0] bits);
        return (^bits) == 1'b0;
    endfunction
`endif

    logic [2:0]       sclk_r;
    logic [1:0]       sen_r;
    logic [1:0]       sdat_r;
    state_t           state_r;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx;
    logic [LEN-1:0]   shift_r;
    logic [LEN-1:0]   shift_nx;
    logic             loaded_r;
    logic             valid_r;
    logic             valid_nx;
    logic [HALF_W-1:0] re_r;
    logic [HALF_W-1:0] re_nx;
    logic [HALF_W-1:0] im_r;
    logic [HALF_W-1:0] im_nx;
    logic             busy_r;
    logic             ovr_r;
    logic             ovr_nx;
    logic             perr_r;
    logic             perr_nx;

    logic             rise_s;
    logic             en_s;
    logic             dat_s;
    logic             load_s;
    logic             parity_bad_s;
    logic [FRAME_W-1:0] payload_s;

    assign rise_s    = sclk_r[1] & ~sclk_r[2];
    assign en_s      = sen_r[1];
    assign dat_s     = sdat_r[1];
    // The completed frame is loaded once, in the first cycle spent in DONE.
    assign load_s    = (state_r == ST_DONE) & ~loaded_r;
    // The parity bit, when present, is the LSB and is not part of the payload.
    assign payload_s = shift_r[LEN-1 -: FRAME_W];
`ifdef SPI_RX_PARITY_EN
    assign parity_bad_s = load_s & ~even_parity_ok(shift_r);
`else
    assign parity_bad_s = 1'b0;
`endif

    // Two-flop synchronizers, plus a third spi_clk flop for rising-edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sclk_r <= 3'b000;
            sen_r  <= 2'b00;
            sdat_r <= 2'b00;
        end else begin
            sclk_r <= {sclk_r[1:0], spi_clk};
            sen_r  <= {sen_r[0], spi_en};
            sdat_r <= {sdat_r[0], spi_data};
        end
    end

    // Receive FSM state, bit counter, shift register and the load-once marker.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            shift_r  <= {LEN{1'b0}};
            loaded_r <= 1'b0;
        end else begin
            state_r  <= state_nx;
            cnt_r    <= cnt_nx;
            shift_r  <= shift_nx;
            loaded_r <= (state_r == ST_DONE);
        end
    end

    // Next-state logic: shift on detected edges, abort on early spi_en drop.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        shift_nx = shift_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nx   = {CNT_W{1'b0}};
                shift_nx = {LEN{1'b0}};
                if (en_s) begin
                    state_nx = ST_SHIFT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!en_s) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = {CNT_W{1'b0}};
                end else if (rise_s) begin
                    shift_nx = {shift_r[LEN-2:0], dat_s};
                    cnt_nx   = cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_SHIFT;
                    end
                end else begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (!en_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = {CNT_W{1'b0}};
                shift_nx = {LEN{1'b0}};
            end
        endcase
    end

    // Holding register: load, drop with overrun/parity flag, or consume.
    always_comb begin
        valid_nx = valid_r;
        re_nx    = re_r;
        im_nx    = im_r;
        ovr_nx   = 1'b0;
        perr_nx  = 1'b0;
        if (parity_bad_s) begin
            perr_nx  = 1'b1;
            valid_nx = valid_r & ~frame_ready;
        end else if (load_s) begin
            if (!valid_r || frame_ready) begin
                valid_nx = 1'b1;
                re_nx    = payload_s[FRAME_W-1:HALF_W];
                im_nx    = payload_s[HALF_W-1:0];
            end else begin
                ovr_nx   = 1'b1;
            end
        end else if (valid_r && frame_ready) begin
            valid_nx = 1'b0;
        end else begin
            valid_nx = valid_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_r <= 1'b0;
            re_r    <= {HALF_W{1'b0}};
            im_r    <= {HALF_W{1'b0}};
            busy_r  <= 1'b0;
            ovr_r   <= 1'b0;
            perr_r  <= 1'b0;
        end else begin
            valid_r <= valid_nx;
            re_r    <= re_nx;
            im_r    <= im_nx;
            busy_r  <= (state_nx == ST_SHIFT);
            ovr_r   <= ovr_nx;
            perr_r  <= perr_nx;
        end
    end

    assign frame_valid = valid_r;
    assign c_re        = re_r;
    assign c_im        = im_r;
    assign busy        = busy_r;
    assign overrun     = ovr_r;
    assign parity_err  = perr_r;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed testbench for spi_frame_rx. A queue holds the expected frames, and
// a monitor compares each one when the pixel-core side accepts it.
module tb_spi_frame_rx;

    localparam int FW = 64;
`ifdef SPI_RX_PARITY_EN
    localparam int NB = FW + 1;
`else
    localparam int NB = FW;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic          spi_clk;
    logic          spi_en;
    logic          spi_data;
    logic          frame_ready;
    logic          frame_valid;
    logic [FW/2-1:0] c_re;
    logic [FW/2-1:0] c_im;
    logic          busy;
    logic          overrun;
    logic          parity_err;

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    logic [63:0] sb[$];

    spi_frame_rx #(.FRAME_W(FW)) dut (
        .clk(clk), .nrst(nrst), .spi_clk(spi_clk), .spi_en(spi_en),
        .spi_data(spi_data), .frame_ready(frame_ready),
        .frame_valid(frame_valid), .c_re(c_re), .c_im(c_im), .busy(busy),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame bits, right-aligned, MSB sent first; pbit is appended in parity builds.
    function automatic logic [127:0] mk(input logic [63:0] v, input logic pbit);
`ifdef SPI_RX_PARITY_EN
        return {63'd0, v, pbit};
`else
        return {64'd0, v} | {127'd0, pbit & 1'b0};
`endif
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift n bits, starting at bit index from-1 and moving downward.
    task automatic shift_bits(input logic [127:0] v, input int from, input int n);
        for (int i = 0; i < n; i++) begin
            spi_data = v[from-1-i];
            wait_n(4);
            spi_clk = 1'b1;
            wait_n(4);
            spi_clk = 1'b0;
        end
    endtask

    // Send a full frame, recording frame_valid for the 6 cycles after the final rising edge.
    task automatic send_frame(input logic [127:0] v, input int rdy_at, output int lat,
                              output logic [7:0] vhist, output logic [63:0] cc_at);
        spi_en = 1'b1;
        wait_n(4);
        shift_bits(v, NB, NB - 1);
        spi_data = v[0];
        wait_n(4);
        spi_clk = 1'b1;
        lat = -1;
        vhist = 8'h00;
        cc_at = 64'd0;
        for (int k = 1; k <= 6; k++) begin
            if (k == rdy_at) frame_ready = 1'b1;
            @(posedge clk);
            #1;
            vhist[k] = frame_valid;
            if (frame_valid && lat < 0) lat = k;
            if (k == rdy_at) cc_at = {c_re, c_im};
            @(negedge clk);
        end
        spi_clk = 1'b0;
        wait_n(4);
        spi_en = 1'b0;
        wait_n(5);
    endtask

    // Scoreboard: each accepted frame must match the oldest expected one; pulses are counted.
    always @(negedge clk) begin
        #2;
        if (nrst) begin
            if (overrun) ovr_cnt++;
            if (parity_err) perr_cnt++;
            if (frame_valid && frame_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_frame observed=%h expected=none", {c_re, c_im});
                end
                if (sb.size() != 0) chk("frame_data", {c_re, c_im}, sb.pop_front());
            end
        end
    end

    initial begin
        int lat;
        int ovr0;
        int perr0;
        logic [7:0] vh;
        logic [63:0] cc;
        logic [63:0] va;
        logic [63:0] vb;
        logic good_clear;

        nrst = 1'b0; spi_clk = 1'b0; spi_en = 1'b0; spi_data = 1'b0; frame_ready = 1'b0;
        wait_n(3);
        chk("rst_valid", 64'(frame_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_parity_err", 64'(parity_err), 64'd0);
        chk("rst_coord", {c_re, c_im}, 64'd0);
        nrst = 1'b1;
        wait_n(3);

        // Basic frame with the core always ready.
        frame_ready = 1'b1;
        va = 64'h1234_5678_9ABC_DEF0;
        sb.push_back(va);
        send_frame(mk(va, ^va), 0, lat, vh, cc);
        chk("basic_latency", 64'(lat >= 1 && lat <= 5), 64'd1);
        good_clear = (lat >= 1 && lat <= 5) ? vh[lat+1] : 1'b1;
        chk("basic_clear", 64'(good_clear), 64'd0);
        chk("basic_sb", 64'(sb.size()), 64'd0);

        // Back-pressure: A is held, B is dropped with an overrun.
        frame_ready = 1'b0;
        va = 64'h1111_1111_1111_1111;
        vb = 64'h2222_2222_2222_2222;
        sb.push_back(va);
        send_frame(mk(va, ^va), 0, lat, vh, cc);
        chk("bp_latency", 64'(lat >= 1 && lat <= 5), 64'd1);
        ovr0 = ovr_cnt;
        send_frame(mk(vb, ^vb), 0, lat, vh, cc);
        chk("bp_overrun", 64'(ovr_cnt - ovr0), 64'd1);
        chk("bp_hold", {c_re, c_im}, va);
        chk("bp_valid", 64'(frame_valid), 64'd1);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'(frame_valid), 64'd0);
        chk("bp_sb", 64'(sb.size()), 64'd0);

        // Simultaneous consume of A and load of B.
        @(negedge clk);
        frame_ready = 1'b0;
        va = 64'hAAAA_5555_0F0F_F0F0;
        vb = 64'h0123_4567_89AB_CDEF;
        sb.push_back(va);
        send_frame(mk(va, ^va), 0, lat, vh, cc);
        sb.push_back(vb);
        ovr0 = ovr_cnt;
        send_frame(mk(vb, ^vb), 4, lat, vh, cc);
        chk("sim_valid_kept", 64'({vh[3], vh[4]}), 64'd3);
        chk("sim_coord", cc, vb);
        chk("sim_no_overrun", 64'(ovr_cnt - ovr0), 64'd0);
        chk("sim_sb", 64'(sb.size()), 64'd0);

        // Aborted frame after 20 bits, then a full frame.
        frame_ready = 1'b1;
        va = 64'hDEAD_BEEF_CAFE_F00D;
        spi_en = 1'b1;
        wait_n(4);
        shift_bits(mk(va, ^va), NB, 20);
        chk("abort_busy", 64'(busy), 64'd1);
        spi_en = 1'b0;
        wait_n(10);
        chk("abort_valid", 64'(frame_valid), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        va = 64'hFFFF_FFFF_0000_0001;
        sb.push_back(va);
        send_frame(mk(va, ^va), 0, lat, vh, cc);
        chk("abort_next_latency", 64'(lat >= 1 && lat <= 5), 64'd1);
        chk("abort_sb", 64'(sb.size()), 64'd0);

        // Reset mid-frame while another frame is held.
        frame_ready = 1'b0;
        va = 64'h5A5A_A5A5_3C3C_C3C3;
        sb.push_back(va);
        send_frame(mk(va, ^va), 0, lat, vh, cc);
        spi_en = 1'b1;
        wait_n(4);
        shift_bits(mk(vb, ^vb), NB, 40);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        chk("midrst_held_before", 64'(frame_valid), 64'd1);
        nrst = 1'b0;
        #1;
        chk("midrst_valid", 64'(frame_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_coord", {c_re, c_im}, 64'd0);
        chk("midrst_flags", 64'({overrun, parity_err}), 64'd0);
        sb.delete();
        spi_en = 1'b0;
        wait_n(3);
        nrst = 1'b1;
        wait_n(3);
        frame_ready = 1'b1;
        va = 64'hC0FF_EE00_1234_ABCD;
        sb.push_back(va);
        send_frame(mk(va, ^va), 0, lat, vh, cc);
        chk("midrst_next_latency", 64'(lat >= 1 && lat <= 5), 64'd1);
        chk("midrst_sb", 64'(sb.size()), 64'd0);

`ifdef SPI_RX_PARITY_EN
        // Parity: bit 0 is wrong for this payload, bit 1 is right.
        perr0 = perr_cnt;
        va = 64'h0000_0000_0000_0001;
        send_frame(mk(va, 1'b0), 0, lat, vh, cc);
        chk("par_bad_pulse", 64'(perr_cnt - perr0), 64'd1);
        chk("par_bad_no_valid", 64'(vh), 64'd0);
        perr0 = perr_cnt;
        sb.push_back(va);
        send_frame(mk(va, 1'b1), 0, lat, vh, cc);
        chk("par_good_pulse", 64'(perr_cnt - perr0), 64'd0);
        chk("par_good_sb", 64'(sb.size()), 64'd0);
`else
        perr0 = 0;
        chk("parity_err_quiet", 64'(perr_cnt - perr0), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
